axi_burst_master: RTL and testbench

- Single-burst AXI4 initiator; the master-side counterpart of the DDR memory responder in simulation and FPGA tops.
- Accepts one command per transaction (address, beat count, direction) and issues exactly one INCR burst on a full AXI4 master port.
- Write data enters through a valid/ready stream; read data leaves through a valid/ready stream.
- Intended use: DMA front-ends and bench traffic generation against the interconnect slave ports.

---
 rtl/axi_burst_master.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// Single-command AXI4 INCR burst initiator: 1-cycle cmd-to-AxVALID, W/R data combinational pass-through.
// Stream ready/valid follow the AXI handshake directly; optional AXI_MASTER_TIMEOUT_EN adds a 16-bit stall watchdog.
module axi_burst_master #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,

  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,

  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,

  output logic                done,
  output logic                err,

  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,

  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,

  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,

  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,

  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);
  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         beat_q, beat_d;
  logic               err_q, err_d;
  logic               to_hit;

  // Transaction IDs are fixed at zero, so response IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'd0;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'd0;

  assign m_axi_wdata   = in_data;
  assign m_axi_wstrb   = '1;
  assign out_data      = m_axi_rdata;
  assign err           = err_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    err_d         = err_q;
    cmd_ready     = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    done          = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;

    if (to_hit) begin
      // Watchdog expiry: all valids/readies stay low this cycle and in DONE.
      state_d = ST_DONE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            addr_d  = cmd_addr & ALIGN_MASK;
            len_d   = cmd_len;
            beat_d  = 8'd0;
            err_d   = 1'b0;
            state_d = cmd_write ? ST_AW : ST_AR;
          end
        end
        ST_AW: begin
          m_axi_awvalid = 1'b1;
          if (m_axi_awready) state_d = ST_W;
        end
        ST_W: begin
          m_axi_wvalid = in_valid;
          in_ready     = m_axi_wready;
          m_axi_wlast  = (beat_q == len_q);
          if (in_valid && m_axi_wready) begin
            beat_d = beat_q + 8'd1;
            if (beat_q == len_q) state_d = ST_B;
          end
        end
        ST_B: begin
          m_axi_bready = 1'b1;
          if (m_axi_bvalid) begin
            err_d   = err_q | (m_axi_bresp != 2'b00);
            state_d = ST_DONE;
          end
        end
        ST_AR: begin
          m_axi_arvalid = 1'b1;
          if (m_axi_arready) state_d = ST_R;
        end
        ST_R: begin
          out_valid    = m_axi_rvalid;
          m_axi_rready = out_ready;
          if (m_axi_rvalid && out_ready) begin
            beat_d = beat_q + 8'd1;
            if (m_axi_rresp != 2'b00) err_d = 1'b1;
            if (m_axi_rlast) begin
              if (beat_q != len_q) err_d = 1'b1;
              state_d = ST_DONE;
            end else if (beat_q == len_q) begin
              // Slave overran the requested length; drain until rlast.
              err_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  logic [15:0] to_q;
  logic        axi_hs;

  assign axi_hs = (m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready) ||
                  (m_axi_bvalid  && m_axi_bready)  || (m_axi_arvalid && m_axi_arready) ||
                  (m_axi_rvalid  && m_axi_rready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q <= 16'd0;
    end else if (state_q == ST_IDLE || state_q == ST_DONE || axi_hs) begin
      to_q <= 16'd0;
    end else begin
      to_q <= to_q + 16'd1;
    end
  end

  assign to_hit = (to_q == 16'hFFFF);
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: transaction-level AXI slave model plus per-cycle output checks.
module tb_axi_burst_master;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int ID_W   = 1;

  logic clk, rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic in_valid, in_ready, out_valid, out_ready, done, err;
  logic [DATA_W-1:0] in_data, out_data;
  logic [ID_W-1:0] m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic m_axi_awlock, m_axi_arlock;
  logic [3:0] m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;

  axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model state
  bit mon_en = 1'b1;
  int cyc = 0;
  bit busy, t_write, aw_done, w_done, b_done, ar_done, r_done;
  bit exp_done_now, exp_av_next, exp_err;
  logic [ADDR_W-1:0] t_addr, aw_addr_seen;
  logic [7:0] t_len;
  int aw_wait, w_cnt, r_cnt, done_cnt, b_cyc, done_cyc;
  logic [DATA_W-1:0] in_q[$];
  logic [DATA_W-1:0] w_log[$];
  logic [DATA_W-1:0] got_q[$];
  bit wl_log[$];

  // Slave / stream behaviour knobs
  int aw_hold = 0;
  bit wr_tog = 0, in_tog = 0, or_tog = 0;
  logic [1:0] cfg_bresp = 2'b00;
  int rd_last_idx = 0;
  int rd_bad = -1;
  logic [DATA_W-1:0] rd_base = '0;

  task automatic clear_model();
    busy = 0; aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0;
    exp_done_now = 0; exp_av_next = 0; aw_wait = 0; w_cnt = 0; r_cnt = 0;
    in_q.delete();
  endtask

  task automatic monitor_cycle();
    bit p_aw, p_w, p_b, p_ar, p_r, nxt;
    logic [ADDR_W-1:0] ea;
    logic [39:0] stat_exp;
    p_aw = busy && t_write && !aw_done;
    p_w  = busy && t_write && aw_done && !w_done;
    p_b  = busy && t_write && w_done && !b_done;
    p_ar = busy && !t_write && !ar_done;
    p_r  = busy && !t_write && ar_done && !r_done;
    ea   = t_addr & ~ADDR_W'(DATA_W/8 - 1);
    stat_exp = {1'b0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0,
                1'b0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0, 4'hF};

    chk("cmd_ready", cmd_ready, !busy);
    chk("done", done, exp_done_now);
    if (done) chk("err", err, exp_err);
    if (exp_av_next) begin
      chk("cmd_to_axvalid", m_axi_awvalid | m_axi_arvalid, 1);
      exp_av_next = 0;
    end
    chk("awvalid", m_axi_awvalid, p_aw);
    if (m_axi_awvalid) begin
      chk("awaddr", m_axi_awaddr, ea);
      chk("awlen", m_axi_awlen, t_len);
    end
    chk("wvalid", m_axi_wvalid, p_w && in_valid);
    chk("in_ready", in_ready, p_w && m_axi_wready);
    if (m_axi_wvalid) begin
      chk("wdata", m_axi_wdata, (in_q.size() > 0) ? in_q[0] : 32'hDEADBEEF);
      chk("wlast", m_axi_wlast, w_cnt == int'(t_len));
    end
    chk("bready", m_axi_bready, p_b);
    chk("arvalid", m_axi_arvalid, p_ar);
    if (m_axi_arvalid) begin
      chk("araddr", m_axi_araddr, ea);
      chk("arlen", m_axi_arlen, t_len);
    end
    chk("rready", m_axi_rready, p_r && out_ready);
    chk("out_valid", out_valid, p_r && m_axi_rvalid);
    if (out_valid) chk("out_data", out_data, rd_base + DATA_W'(r_cnt));
    chk("static_fields", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache,
                          m_axi_awprot, m_axi_awqos, m_axi_arid, m_axi_arsize, m_axi_arburst,
                          m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_wstrb},
        stat_exp);

    nxt = 0;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy = 0;
    end
    if (cmd_valid && cmd_ready) begin
      busy = 1; t_write = cmd_write; t_addr = cmd_addr; t_len = cmd_len;
      aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0;
      aw_wait = 0; w_cnt = 0; r_cnt = 0;
      w_log.delete(); wl_log.delete(); got_q.delete();
      exp_av_next = 1;
    end
    if (m_axi_awvalid && m_axi_awready) begin
      aw_done = 1;
      aw_addr_seen = m_axi_awaddr;
    end else if (m_axi_awvalid) begin
      aw_wait++;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_log.push_back(m_axi_wdata);
      wl_log.push_back(m_axi_wlast);
      if (in_q.size() > 0) void'(in_q.pop_front());
      w_cnt++;
      if (w_cnt == int'(t_len) + 1) w_done = 1;
    end
    if (m_axi_bvalid && m_axi_bready) begin
      b_done = 1; nxt = 1; b_cyc = cyc;
    end
    if (m_axi_arvalid && m_axi_arready) ar_done = 1;
    if (m_axi_rvalid && m_axi_rready) begin
      got_q.push_back(out_data);
      r_cnt++;
      if (m_axi_rlast) begin
        r_done = 1; nxt = 1;
      end
    end
    exp_done_now = nxt;
  endtask

  task automatic drive_slave();
    bit p_b, p_r;
    p_b = busy && t_write && w_done && !b_done;
    p_r = busy && !t_write && ar_done && !r_done;
    m_axi_awready = (aw_wait >= aw_hold);
    m_axi_wready  = wr_tog ? (cyc % 2 == 1) : 1'b1;
    in_valid      = (in_q.size() > 0) && (!in_tog || (cyc % 3 != 0));
    in_data       = (in_q.size() > 0) ? in_q[0] : '0;
    m_axi_bvalid  = p_b;
    m_axi_bresp   = cfg_bresp;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = p_r;
    m_axi_rdata   = rd_base + DATA_W'(r_cnt);
    m_axi_rlast   = (r_cnt == rd_last_idx);
    m_axi_rresp   = (r_cnt == rd_bad) ? 2'b10 : 2'b00;
    out_ready     = or_tog ? (cyc % 2 == 1) : 1'b1;
  endtask

  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
    m_axi_bid = '0; m_axi_rid = '0;
    in_valid = 0; in_data = 0; out_ready = 0;
    clear_model();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst || !mon_en) clear_model();
      else monitor_cycle();
      @(posedge clk);
      #1;
      drive_slave();
    end
  end

  task automatic send_cmd(input bit wr, input logic [ADDR_W-1:0] a, input logic [7:0] l);
    bit ok;
    ok = 0;
    @(posedge clk); #2;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #2;
    cmd_valid = 0;
    chk("cmd_accept", ok, 1);
  endtask

  task automatic wait_done(input int n0, input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (done_cnt != n0) begin ok = 1; break; end
    end
    chk("done_seen", ok, 1);
  endtask

  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [7:0] l, input bit e);
    int n0;
    exp_err = e;
    rd_last_idx = (rd_last_idx < 0) ? int'(l) : rd_last_idx;
    n0 = done_cnt;
    send_cmd(wr, a, l);
    wait_done(n0, 3000);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int ones;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                     in_ready, out_valid, done, err}, 9'd0);
    repeat (3) @(posedge clk);
    #3 rst = 0;

    // Write 0x100, len 3
    for (int i = 0; i < 4; i++) in_q.push_back(32'hA0 + i);
    rd_last_idx = -1;
    run_txn(1, 30'h100, 8'd3, 0);
    chk("t1_awaddr", aw_addr_seen, 30'h100);
    chk("t1_beats", w_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_wdata", w_log[i], 32'hA0 + i);
      chk("t1_wlast", wl_log[i], i == 3);
    end
    chk("t1_done_after_b", done_cyc - b_cyc, 1);

    // Read 0x200, len 7, out_ready 1010...
    or_tog = 1; rd_base = 0; rd_last_idx = 7;
    run_txn(0, 30'h200, 8'd7, 0);
    chk("t2_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_data", got_q[i], i);
    or_tog = 0;

    // len 0 write then read
    in_q.push_back(32'h55);
    run_txn(1, 30'h40, 8'd0, 0);
    chk("t3_wbeats", w_log.size(), 1);
    chk("t3_wlast0", wl_log[0], 1);
    rd_base = 32'h77; rd_last_idx = 0;
    run_txn(0, 30'h80, 8'd0, 0);
    chk("t3_rbeats", got_q.size(), 1);
    chk("t3_rdata", got_q[0], 32'h77);

    // Early rlast on beat 2 of len 3
    rd_base = 32'h10; rd_last_idx = 2;
    run_txn(0, 30'h300, 8'd3, 1);
    chk("t4_rbeats", got_q.size(), 3);

    // SLVERR on write, then clean read
    cfg_bresp = 2'b10;
    in_q.push_back(32'h1); in_q.push_back(32'h2);
    run_txn(1, 30'h400, 8'd1, 1);
    cfg_bresp = 2'b00; rd_last_idx = 1;
    run_txn(0, 30'h500, 8'd1, 0);
    chk("t5_rbeats", got_q.size(), 2);

    // Late rlast (beats past len) and a bad rresp mid-burst
    rd_last_idx = 3;
    run_txn(0, 30'h600, 8'd1, 1);
    chk("t6_late_beats", got_q.size(), 4);
    rd_last_idx = 2; rd_bad = 1;
    run_txn(0, 30'h700, 8'd2, 1);
    rd_bad = -1;

    // Unaligned 256-beat write with stalls on every side
    aw_hold = 2; wr_tog = 1; in_tog = 1;
    for (int i = 0; i < 256; i++) in_q.push_back(32'h1000 + 3 * i);
    run_txn(1, 30'h103, 8'd255, 0);
    chk("t7_awaddr", aw_addr_seen, 30'h100);
    chk("t7_beats", w_log.size(), 256);
    ones = 0;
    for (int i = 0; i < w_log.size(); i++) begin
      if (w_log[i] !== 32'h1000 + 3 * i) chk("t7_wdata", w_log[i], 32'h1000 + 3 * i);
      if (wl_log[i]) ones++;
    end
    chk("t7_wlast_count", ones, 1);
    chk("t7_wlast_pos", wl_log[255], 1);
    aw_hold = 0; in_tog = 0;

    // Reset in the middle of a W burst
    exp_err = 0;
    for (int i = 0; i < 8; i++) in_q.push_back(32'hC0 + i);
    begin
      int n0;
      bit ok;
      n0 = done_cnt;
      ok = 0;
      send_cmd(1, 30'h800, 8'd7);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (w_cnt >= 3) begin ok = 1; break; end
      end
      chk("t8_reached_w", ok, 1);
      @(posedge clk); #3 rst = 1;
      #1;
      chk("t8_valids_drop", {m_axi_awvalid, m_axi_wvalid, in_ready, m_axi_bready,
                             m_axi_arvalid, m_axi_rready, out_valid, done}, 8'd0);
      chk("t8_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      @(posedge clk); #3 rst = 0;
      repeat (10) @(negedge clk);
      #1;
      chk("t8_no_done", done_cnt, n0);
    end
    wr_tog = 0;

`ifdef AXI_MASTER_TIMEOUT_EN
    begin
      bit ok;
      int k;
      mon_en = 0; aw_hold = 1;
      ok = 0; k = 0;
      send_cmd(1, 30'h900, 8'd0);
      for (int i = 0; i < 70000; i++) begin
        @(negedge clk);
        if (done) begin ok = 1; k = i; break; end
      end
      chk("t9_timeout_done", ok, 1);
      chk("t9_timeout_err", err, 1);
      chk("t9_timeout_window", (k >= 65530) && (k <= 65545), 1);
      @(negedge clk);
      chk("t9_idle_after", {m_axi_awvalid, cmd_ready}, 2'b01);
      @(posedge clk); #3 rst = 1;
      @(negedge clk);
      @(posedge clk); #3 rst = 0;
      aw_hold = 0; mon_en = 1;
    end
`endif

    // Confirm the block is usable after reset
    rd_base = 32'h20; rd_last_idx = 1;
    run_txn(0, 30'hA00, 8'd1, 0);
    chk("t10_rbeats", got_q.size(), 2);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
